// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, single-outstanding imem requests, redirect and bubble insertion.
// Define FETCH_ALIGN_CHECK_EN to trap misaligned redirect targets in a FAULT state.
module fetch_unit #(
    parameter int                     BUS_WIDTH   = 64,
    parameter int                     INSTR_WIDTH = 32,
    parameter logic [BUS_WIDTH-1:0]   RESET_PC    = '0,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = INSTR_WIDTH'(32'h00000013)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   redirect,
    input  logic [BUS_WIDTH-1:0]   redirect_pc,
    output logic                   imem_req,
    output logic [BUS_WIDTH-1:0]   imem_addr,
    input  logic                   imem_ready,
    input  logic                   imem_rvalid,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic [BUS_WIDTH-1:0]   out_pc,
    output logic [INSTR_WIDTH-1:0] out_instr,
    output logic                   out_valid,
    output logic                   fault
);

`ifdef FETCH_ALIGN_CHECK_EN
    typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, FAULT} state_t;
`else
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;
`endif

    state_t                 state_q, state_d;
    logic [BUS_WIDTH-1:0]   pc_q, pc_d;
    logic                   outValid_q, outValid_d;
    logic [BUS_WIDTH-1:0]   outPc_q, outPc_d;
    logic [INSTR_WIDTH-1:0] outInstr_q, outInstr_d;
    logic                   accept;
    logic                   inFlight;
    logic [BUS_WIDTH-1:0]   target;

    // Only issue when the output slot will be free by the time the response can return.
    assign imem_req  = (state_q == REQ) && (!outValid_q || !stall);
    assign imem_addr = pc_q;
    assign accept    = imem_req && imem_ready;

    assign out_pc    = outPc_q;
    assign out_instr = outInstr_q;
    assign out_valid = outValid_q;

`ifdef FETCH_ALIGN_CHECK_EN
    logic fault_q, fault_d;
    logic pending_q, pending_d;
    logic misaligned;

    assign target     = redirect_pc;
    assign misaligned = |redirect_pc[1:0];
    assign fault      = fault_q;
    // A request still owed a response after this edge must be drained before the next issue.
    assign inFlight   = accept
                     || (((state_q == WAIT) || (state_q == DRAIN)) && !imem_rvalid)
                     || ((state_q == FAULT) && pending_q && !imem_rvalid);
`else
    assign target   = redirect_pc & ~BUS_WIDTH'(3);
    assign fault    = 1'b0;
    assign inFlight = accept
                   || (((state_q == WAIT) || (state_q == DRAIN)) && !imem_rvalid);
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        outValid_d = outValid_q;
        outPc_d    = outPc_q;
        outInstr_d = outInstr_q;
`ifdef FETCH_ALIGN_CHECK_EN
        fault_d    = fault_q;
        pending_d  = pending_q;
`endif
        if (outValid_q && !stall) begin
            outValid_d = 1'b0;
            outInstr_d = NOP_INSTR;
        end

        case (state_q)
            IDLE:  state_d = REQ;
            REQ:   if (accept) state_d = WAIT;
            WAIT: begin
                if (imem_rvalid) begin
                    state_d    = REQ;
                    outValid_d = 1'b1;
                    outPc_d    = pc_q;
                    outInstr_d = imem_rdata;
                    pc_d       = pc_q + BUS_WIDTH'(4);
                end
            end
            DRAIN: if (imem_rvalid) state_d = REQ;
`ifdef FETCH_ALIGN_CHECK_EN
            FAULT: if (imem_rvalid) pending_d = 1'b0;
`endif
            default: state_d = IDLE;
        endcase

        // Redirect wins over capture and stall; a response arriving now is stale and dropped.
        if (redirect) begin
            pc_d       = target;
            outValid_d = 1'b0;
            outPc_d    = outPc_q;
            outInstr_d = NOP_INSTR;
            state_d    = inFlight ? DRAIN : REQ;
`ifdef FETCH_ALIGN_CHECK_EN
            fault_d    = misaligned;
            pending_d  = misaligned && inFlight;
            if (misaligned) state_d = FAULT;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            outValid_q <= 1'b0;
            outPc_q    <= '0;
            outInstr_q <= NOP_INSTR;
`ifdef FETCH_ALIGN_CHECK_EN
            fault_q    <= 1'b0;
            pending_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            outValid_q <= outValid_d;
            outPc_q    <= outPc_d;
            outInstr_q <= outInstr_d;
`ifdef FETCH_ALIGN_CHECK_EN
            fault_q    <= fault_d;
            pending_q  <= pending_d;
`endif
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed vector table, random traffic against a flag-based fetch model,
// and hand sequences for wrap, mid-transaction reset and misaligned redirect (FETCH_ALIGN_CHECK_EN).
module tb_fetch_unit;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        out_valid;
    logic        fault;

    int testsRun    = 0;
    int testsFailed = 0;

    fetch_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .out_pc(out_pc), .out_instr(out_instr), .out_valid(out_valid), .fault(fault)
    );

    always #5 clk = ~clk;

    // Reference model: the fetch stage as a few facts (started, request outstanding, outstanding is stale, slot).
    bit          mStarted, mInFlight, mStale, mSlotValid, mFault;
    logic [63:0] mPc, mSlotPc;
    logic [31:0] mSlotInstr;

    typedef struct {
        logic st, rd; logic [63:0] rpc; logic rdy, rv;
        logic expReq; logic [63:0] expAddr; logic expValid; logic [63:0] expPc; logic [31:0] expInstr;
    } vec_t;
    vec_t vecs[$];

    function automatic logic [31:0] memData(input logic [63:0] a);
        return {a[23:0], 8'h6F};
    endfunction

    function automatic logic modelReq();
        return mStarted && !mInFlight && !mFault && (!mSlotValid || !stall);
    endfunction

    task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic rd, input logic [63:0] rpc,
                                 input logic rdy, input logic rv, input logic [31:0] rdat);
        stall = st; redirect = rd; redirect_pc = rpc;
        imem_ready = rdy; imem_rvalid = rv; imem_rdata = rdat;
        #1;
    endtask

    task automatic checkOutput(input string tag);
        compare({tag, "_req"}, imem_req, modelReq());
        if (modelReq()) compare({tag, "_addr"}, imem_addr, mPc);
        compare({tag, "_valid"}, out_valid, mSlotValid);
        compare({tag, "_instr"}, out_instr, mSlotValid ? mSlotInstr : NOP);
        if (mSlotValid) compare({tag, "_pc"}, out_pc, mSlotPc);
        compare({tag, "_fault"}, fault, mFault);
    endtask

    task automatic advance();
        logic accept, resp;
        accept = modelReq() && imem_ready;
        resp   = imem_rvalid && mInFlight;
        if (redirect) begin
            mSlotValid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            mPc    = redirect_pc;
            mFault = |redirect_pc[1:0];
`else
            mPc    = redirect_pc & ~64'd3;
`endif
            if (resp) mInFlight = 1'b0;
            else if (accept || mInFlight) begin mInFlight = 1'b1; mStale = 1'b1; end
        end else begin
            if (mSlotValid && !stall) mSlotValid = 1'b0;
            if (resp) begin
                mInFlight = 1'b0;
                if (!mStale) begin
                    mSlotValid = 1'b1; mSlotPc = mPc; mSlotInstr = imem_rdata; mPc = mPc + 64'd4;
                end
            end
            if (accept) begin mInFlight = 1'b1; mStale = 1'b0; end
        end
        mStarted = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic doReset(input int n);
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        repeat (n) @(posedge clk);
        @(negedge clk);
        #1;
        compare("rst_req", imem_req, 1'b0);
        compare("rst_addr", imem_addr, 64'h0);
        compare("rst_valid", out_valid, 1'b0);
        compare("rst_pc", out_pc, 64'h0);
        compare("rst_instr", out_instr, NOP);
        compare("rst_fault", fault, 1'b0);
        rst = 1'b0;
        mStarted = 0; mInFlight = 0; mStale = 0; mSlotValid = 0; mFault = 0;
        mPc = 64'h0; mSlotPc = '0; mSlotInstr = NOP;
    endtask

    task automatic addRow(input logic st, input logic rd, input logic [63:0] rpc, input logic rdy,
                          input logic rv, input logic er, input logic [63:0] ea, input logic ev,
                          input logic [63:0] ep, input logic [31:0] ei);
        vecs.push_back('{st, rd, rpc, rdy, rv, er, ea, ev, ep, ei});
    endtask

    initial begin
        logic [63:0] lastAcc;
        bit          memPend;
        int          memDue;
        logic        rv, rd, st, rdy;
        logic [63:0] rpc;

        // Reset, three sequential fetches, a five-cycle stall, redirect while waiting, redirect+rvalid+stall.
        addRow(0,0,0,1,0, 0,0,     0,0,     NOP);
        addRow(0,0,0,1,0, 1,64'h0, 0,0,     NOP);
        addRow(0,0,0,1,1, 0,0,     0,0,     NOP);
        addRow(0,0,0,1,0, 1,64'h4, 1,64'h0, memData(64'h0));
        addRow(0,0,0,1,1, 0,0,     0,0,     NOP);
        addRow(0,0,0,1,0, 1,64'h8, 1,64'h4, memData(64'h4));
        addRow(0,0,0,1,1, 0,0,     0,0,     NOP);
        for (int i = 0; i < 5; i++) addRow(1,0,0,1,0, 0,0, 1,64'h8, memData(64'h8));
        addRow(0,0,0,1,0, 1,64'hC, 1,64'h8, memData(64'h8));
        addRow(0,0,0,1,1, 0,0,     0,0,     NOP);
        addRow(0,0,0,1,0, 1,64'h10,1,64'hC, memData(64'hC));
        addRow(0,1,64'h100,1,0, 0,0, 0,0,   NOP);
        addRow(0,0,0,1,0, 0,0,     0,0,     NOP);
        addRow(0,0,0,1,0, 0,0,     0,0,     NOP);
        addRow(0,0,0,1,1, 0,0,     0,0,     NOP);
        addRow(0,0,0,1,0, 1,64'h100,0,0,    NOP);
        addRow(0,0,0,1,1, 0,0,     0,0,     NOP);
        addRow(0,0,0,1,0, 1,64'h104,1,64'h100, memData(64'h100));
        addRow(1,1,64'h100,1,1, 0,0, 0,0,   NOP);
        addRow(1,0,0,0,0, 1,64'h100,0,0,    NOP);
        addRow(0,0,0,1,0, 1,64'h100,0,0,    NOP);
        addRow(0,0,0,1,1, 0,0,     0,0,     NOP);
        addRow(0,0,0,1,0, 1,64'h104,1,64'h100, memData(64'h100));

        doReset(2);
        lastAcc = '0;
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].st, vecs[i].rd, vecs[i].rpc, vecs[i].rdy, vecs[i].rv, memData(lastAcc));
            compare($sformatf("vec%0d_req", i), imem_req, vecs[i].expReq);
            if (vecs[i].expReq) compare($sformatf("vec%0d_addr", i), imem_addr, vecs[i].expAddr);
            compare($sformatf("vec%0d_valid", i), out_valid, vecs[i].expValid);
            compare($sformatf("vec%0d_instr", i), out_instr, vecs[i].expInstr);
            if (vecs[i].expValid) compare($sformatf("vec%0d_pc", i), out_pc, vecs[i].expPc);
            if (imem_req && imem_ready) lastAcc = imem_addr;
            advance();
        end

        // Random traffic: variable memory latency and ready, random stall and redirect.
        doReset(2);
        memPend = 0; memDue = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            rv  = memPend && (cyc == memDue);
            rd  = ($urandom_range(0, 15) == 0);
            rpc = {$urandom, $urandom};
            st  = ($urandom_range(0, 3) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            applyStimulus(st, rd, rpc, rdy, rv, $urandom);
            checkOutput($sformatf("rand%0d", cyc));
            if (rv) memPend = 0;
            if (modelReq() && rdy) begin memPend = 1; memDue = cyc + $urandom_range(1, 3); end
            advance();
        end

        // PC wrap at the top of the address space.
        doReset(2);
        applyStimulus(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 0); checkOutput("wrap0"); advance();
        applyStimulus(0, 0, 0, 1, 0, 0); checkOutput("wrap1");
        compare("wrap_req_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC); advance();
        applyStimulus(0, 0, 0, 1, 1, 32'h1234_5678); checkOutput("wrap2"); advance();
        applyStimulus(0, 0, 0, 0, 0, 0); checkOutput("wrap3");
        compare("wrap_next_addr", imem_addr, 64'h0);
        compare("wrap_out_pc", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        advance();

        // Reset while waiting; the late response lands in IDLE and must be ignored.
        doReset(2);
        applyStimulus(0, 0, 0, 1, 0, 0); checkOutput("mrst0"); advance();
        applyStimulus(0, 0, 0, 1, 0, 0); checkOutput("mrst1"); advance();
        applyStimulus(0, 0, 0, 0, 0, 0); checkOutput("mrst2");
        doReset(1);
        applyStimulus(0, 0, 0, 0, 1, 32'hDEAD_BEEF); checkOutput("mrst3"); advance();
        applyStimulus(0, 0, 0, 0, 0, 0); checkOutput("mrst4");
        compare("mrst_stale_valid", out_valid, 1'b0);
        compare("mrst_req", imem_req, 1'b1);
        compare("mrst_req_addr", imem_addr, 64'h0);
        advance();

        // Misaligned redirect target.
        doReset(2);
        applyStimulus(0, 1, 64'h102, 1, 0, 0); checkOutput("mis0"); advance();
`ifdef FETCH_ALIGN_CHECK_EN
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 1, 0, 0); checkOutput($sformatf("flt%0d", i));
            compare("fault_flag", fault, 1'b1);
            compare("fault_no_req", imem_req, 1'b0);
            advance();
        end
        applyStimulus(0, 1, 64'h200, 1, 0, 0); checkOutput("flt_redir"); advance();
        applyStimulus(0, 0, 0, 1, 0, 0); checkOutput("flt_clear");
        compare("fault_cleared", fault, 1'b0);
        compare("fault_req", imem_req, 1'b1);
        compare("fault_req_addr", imem_addr, 64'h200);
        advance();
`else
        applyStimulus(0, 0, 0, 1, 0, 0); checkOutput("mis1");
        compare("align_req", imem_req, 1'b1);
        compare("align_req_addr", imem_addr, 64'h100);
        compare("align_fault", fault, 1'b0);
        advance();
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that produces the `{pc, instr}` pair consumed by the IF/ID pipeline register. It owns the program counter and issues single-outstanding requests to instruction memory over a request/response handshake. It redirects on branch/jump resolution and discards stale in-flight responses. When its output slot is empty it presents a NOP bubble, so IF/ID needs no valid bit.

## Interface
- `BUS_WIDTH`, 64, PC/address width
- `INSTR_WIDTH`, 32, instruction width
- `RESET_PC`, 0, first fetch address after reset
- `NOP_INSTR`, 32'h00000013, bubble encoding driven when output invalid

- `clk` in 1: clock
- `rst` in 1: reset, synchronous, active-high
- `stall` in 1: hazard-unit stall, same signal that freezes IF/ID
- `redirect` in 1: control-flow change from EX
- `redirect_pc` in BUS_WIDTH: redirect target
- `imem_req` out 1: request valid
- `imem_addr` out BUS_WIDTH: request address
- `imem_ready` in 1: memory accepts request this cycle
- `imem_rvalid` in 1: response valid
- `imem_rdata` in INSTR_WIDTH: response instruction
- `out_pc` out BUS_WIDTH: PC of presented instruction
- `out_instr` out INSTR_WIDTH: instruction, or NOP_INSTR when `out_valid`=0
- `out_valid` out 1: output slot holds a real instruction
- `fault` out 1: misaligned redirect (only with FETCH_ALIGN_CHECK_EN; else tied 0)

## Operation
- States: IDLE, REQ, WAIT, DRAIN, FAULT (FAULT only with the macro).
- IDLE: entered on reset. Unconditionally goes to REQ on the next cycle.
- REQ:
  - `imem_req`=1 and `imem_addr`=pc when `~out_valid | ~stall`; otherwise `imem_req`=0.
  - Transaction accepted on `imem_req & imem_ready` → WAIT.
- WAIT, on `imem_rvalid`:
  - Registers out_instr=imem_rdata, out_pc=pc, out_valid=1.
  - pc<=pc+4 (modulo 2^BUS_WIDTH) → REQ.
- Consumption: output consumed at an edge where `out_valid & ~stall`. Then out_valid<=0, unless a new response is captured at the same edge.
- One outstanding request maximum. Issue gating guarantees the output slot is free when a response arrives.
- Redirect (priority over stall and over response capture), at the edge:
  - out_valid<=0, pc<=redirect_pc.
  - From IDLE/REQ with no acceptance this cycle → REQ.
  - From WAIT without rvalid, or REQ with acceptance this cycle → DRAIN.
  - From WAIT with rvalid this cycle → REQ, response discarded.
- DRAIN: `imem_req`=0. On `imem_rvalid`, response discarded → REQ. A redirect in DRAIN updates pc and stays in DRAIN.
- `imem_rvalid` seen in IDLE or REQ: ignored (stale after reset).
- Reset values: pc=RESET_PC, state=IDLE, out_valid=0, out_pc=0, out_instr=NOP_INSTR, imem_req=0, imem_addr=RESET_PC, fault=0.

## Timing
- Reset released at edge N → IDLE in cycle N. First `imem_req` at RESET_PC in cycle N+1.
- Response in cycle M → out_valid=1 in M+1. Next request (pc+4) may issue in M+1.
- Throughput with 1-cycle memory and no stall: one instruction per 2 cycles.
- Redirect asserted in cycle R (no request in flight) → `imem_req` with redirect_pc in R+1. out_valid=0 in R+1.
- `stall` with out_valid=1: out_pc/out_instr/out_valid held; no new request issued.
- Outputs are registered. `imem_req`/`imem_addr` are combinational from state, pc, out_valid and stall only. There is no path from imem_ready/imem_rvalid to `imem_req`.
- `rst` mid-transaction: state returns to IDLE. Any later response is ignored per the rules above.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - redirect_pc[1:0]!=0 → FAULT at next edge. fault=1, out_valid=0, `imem_req`=0.
  - FAULT is left only on a new aligned redirect, which clears fault → REQ (or DRAIN if a request is in flight).
  - Only reset or a redirect clears fault.
- Undefined: redirect_pc[1:0] forced to 0, no FAULT state, fault tied 0.

## Test plan
- Reset, memory ready/1-cycle latency returning addr-derived data → out_pc sequence 0,4,8 with out_valid pulses; out_instr=0x13 between.
- stall=1 for 5 cycles while out_valid=1 at pc=0x8 → outputs frozen; `imem_req`=0 for all 5 cycles; fetch of 0xC issues the cycle stall drops.
- redirect to 0x100 while in WAIT for 0x10, response arriving 3 cycles later → response dropped; out_valid never 1 for 0x10; next request 0x100.
- redirect, rvalid and stall=1 in the same cycle → response discarded, out_valid=0 next cycle, `imem_req` addr=0x100 in REQ.
- pc=0xFFFF_FFFF_FFFF_FFFC fetched → next request address 0x0.
- With FETCH_ALIGN_CHECK_EN: redirect to 0x102 → fault=1, no requests. Then redirect to 0x200 → fault=0, request to 0x200.
